// File: rtl/entropy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : entropy_pkg
// Description : Shared types and constants for the entropy-coder stage-2
//               scheduler: FSM state encoding, range reset value and
//               requester grant encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package entropy_pkg;

    // Scheduler frame state; explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Range value loaded at the start of every frame (1.0 in Q15)
    localparam logic [15:0] RANGE_INIT = 16'h8000;

    // Grant encoding used by the round-robin arbiter's history bit
    localparam logic GNT_CDF  = 1'b0;
    localparam logic GNT_BOOL = 1'b1;

endpackage : entropy_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter between the CDF and bool
//               requesters. Grants are purely combinational from the
//               enable, the requests and the stored last-grant history.
//               History only advances on an actual issue.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import entropy_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_req_cdf,
    input  logic i_req_bool,
    input  logic i_advance,
    output logic o_gnt_cdf,
    output logic o_gnt_bool
);

    logic r_last_grant;

    // Pick a winner: single requester wins outright, a tie goes to the side not served last
    always_comb begin
        o_gnt_cdf  = 1'b0;
        o_gnt_bool = 1'b0;
        if (i_enable) begin
            if (i_req_cdf && i_req_bool) begin
                o_gnt_cdf  = (r_last_grant == GNT_BOOL);
                o_gnt_bool = (r_last_grant == GNT_CDF);
            end else begin
                o_gnt_cdf  = i_req_cdf;
                o_gnt_bool = i_req_bool;
            end
        end
    end

    // Remember who was served on each issue; reset favours CDF for the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GNT_BOOL;
        end else if (i_advance) begin
            r_last_grant <= o_gnt_bool ? GNT_BOOL : GNT_CDF;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/stage_2_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : stage_2_scheduler
// Description : Sequencer/arbiter in front of the shared stage-2 datapath.
//               Merges CDF and bool requesters round-robin, owns the range
//               feedback register, registers datapath results into a
//               valid/ready output slot and frames each tile with a range
//               reset at start and a terminating flush beat at end.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_2_scheduler
    import entropy_pkg::*;
#(
    parameter int RANGE_WIDTH  = 16,
    parameter int D_SIZE       = 5,
    parameter int SYMBOL_WIDTH = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    frame_start,
    input  logic                    frame_end,
    // CDF requester
    input  logic                    cdf_valid,
    output logic                    cdf_ready,
    input  logic [RANGE_WIDTH-1:0]  cdf_uu,
    input  logic [RANGE_WIDTH-1:0]  cdf_vv,
    input  logic [RANGE_WIDTH-1:0]  cdf_lut_u,
    input  logic [RANGE_WIDTH-1:0]  cdf_lut_v,
    input  logic                    cdf_comp,
    // Bool requester
    input  logic                    bool_valid,
    output logic                    bool_ready,
    input  logic                    bool_bit,
    // Datapath operands
    output logic [RANGE_WIDTH-1:0]  s2_uu,
    output logic [RANGE_WIDTH-1:0]  s2_vv,
    output logic [RANGE_WIDTH-1:0]  s2_lut_u,
    output logic [RANGE_WIDTH-1:0]  s2_lut_v,
    output logic [RANGE_WIDTH-1:0]  s2_in_range,
    output logic                    s2_comp,
    output logic                    s2_bool_flag,
    output logic [SYMBOL_WIDTH-1:0] s2_symbol,
    // Datapath results
    input  logic [RANGE_WIDTH:0]    s2_u,
    input  logic [RANGE_WIDTH:0]    s2_v_bool,
    input  logic [RANGE_WIDTH-1:0]  s2_out_range,
    input  logic [D_SIZE-1:0]       s2_out_d,
    // Downstream slot
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RANGE_WIDTH:0]    out_u,
    output logic [RANGE_WIDTH:0]    out_v_bool,
    output logic [RANGE_WIDTH-1:0]  out_initial_range,
    output logic [D_SIZE-1:0]       out_d,
    output logic [1:0]              out_bool_symbol,
    output logic                    out_comp,
    output logic                    out_last,
    // Status
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    sym_count
);

    // Half-scale range; the package constant is used directly at the native width
    localparam logic [RANGE_WIDTH-1:0] c_RANGE_INIT =
        (RANGE_WIDTH == 16) ? RANGE_WIDTH'(RANGE_INIT)
                            : (RANGE_WIDTH'(1) << (RANGE_WIDTH - 1));

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [RANGE_WIDTH-1:0]   r_range;
    logic [CNT_WIDTH-1:0]     r_sym_count;

    logic                     r_out_valid;
    logic [RANGE_WIDTH:0]     r_out_u;
    logic [RANGE_WIDTH:0]     r_out_v_bool;
    logic [RANGE_WIDTH-1:0]   r_out_initial_range;
    logic [D_SIZE-1:0]        r_out_d;
    logic [1:0]               r_out_bool_symbol;
    logic                     r_out_comp;
    logic                     r_out_last;

    logic                     w_slot_free;
    logic                     w_arb_en;
    logic                     w_flush_load;
    logic                     w_frame_init;
    logic                     w_busy;
    logic                     w_gnt_cdf;
    logic                     w_gnt_bool;
    logic                     w_issue;

    // The slot can accept a new beat when empty or being drained this cycle
    assign w_slot_free = !r_out_valid || out_ready;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: start only from IDLE, end only from RUN, flush leaves on a free slot
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (frame_start) w_state_nxt = ST_RUN;
            ST_RUN:   if (frame_end)   w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_slot_free) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded controls: arbitration window, flush load, frame init, busy
    always_comb begin
        w_arb_en     = 1'b0;
        w_flush_load = 1'b0;
        w_frame_init = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy       = 1'b0;
                w_frame_init = frame_start;
            end
            ST_RUN: begin
                w_arb_en = !frame_end && w_slot_free;
            end
            ST_FLUSH: begin
                w_flush_load = w_slot_free;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    rr_arbiter2 u_arb (
        .clk        (clk),
        .rst_n      (reset_n),
        .i_enable   (w_arb_en),
        .i_req_cdf  (cdf_valid),
        .i_req_bool (bool_valid),
        .i_advance  (w_issue),
        .o_gnt_cdf  (w_gnt_cdf),
        .o_gnt_bool (w_gnt_bool)
    );

    // A grant is only ever given to a valid requester, so grant implies issue
    assign cdf_ready  = w_gnt_cdf;
    assign bool_ready = w_gnt_bool;
    assign w_issue    = (cdf_valid && w_gnt_cdf) || (bool_valid && w_gnt_bool);

    // Operand mux onto the datapath; idle operands are zero, range always fed back
    always_comb begin
        s2_uu        = '0;
        s2_vv        = '0;
        s2_lut_u     = '0;
        s2_lut_v     = '0;
        s2_comp      = 1'b0;
        s2_bool_flag = 1'b0;
        s2_symbol    = '0;
        s2_in_range  = r_range;
        if (w_gnt_cdf) begin
            s2_uu    = cdf_uu;
            s2_vv    = cdf_vv;
            s2_lut_u = cdf_lut_u;
            s2_lut_v = cdf_lut_v;
            s2_comp  = cdf_comp;
        end else if (w_gnt_bool) begin
            s2_bool_flag = 1'b1;
            s2_symbol[0] = bool_bit;
        end
    end

    // ------------------------------------------------------------------------
    // Range feedback and symbol counter
    // ------------------------------------------------------------------------

    // Reset range/count at frame start; chain the normalized range on every issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_range     <= c_RANGE_INIT;
            r_sym_count <= '0;
        end else if (w_frame_init) begin
            r_range     <= c_RANGE_INIT;
            r_sym_count <= '0;
        end else if (w_issue) begin
            r_range <= s2_out_range;
            if (r_sym_count != {CNT_WIDTH{1'b1}}) begin
                r_sym_count <= r_sym_count + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output slot
    // ------------------------------------------------------------------------

    // Load an issued symbol or the flush beat; otherwise hold while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid         <= 1'b0;
            r_out_u             <= '0;
            r_out_v_bool        <= '0;
            r_out_initial_range <= '0;
            r_out_d             <= '0;
            r_out_bool_symbol   <= '0;
            r_out_comp          <= 1'b0;
            r_out_last          <= 1'b0;
        end else if (w_issue) begin
            r_out_valid         <= 1'b1;
            r_out_u             <= s2_u;
            r_out_v_bool        <= s2_v_bool;
            r_out_initial_range <= r_range;
            r_out_d             <= s2_out_d;
            r_out_bool_symbol   <= {s2_bool_flag, s2_symbol[0]};
            r_out_comp          <= s2_comp;
            r_out_last          <= 1'b0;
        end else if (w_flush_load) begin
            r_out_valid         <= 1'b1;
            r_out_u             <= '0;
            r_out_v_bool        <= '0;
            r_out_initial_range <= r_range;
            r_out_d             <= '0;
            r_out_bool_symbol   <= '0;
            r_out_comp          <= 1'b0;
            r_out_last          <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid         = r_out_valid;
    assign out_u             = r_out_u;
    assign out_v_bool        = r_out_v_bool;
    assign out_initial_range = r_out_initial_range;
    assign out_d             = r_out_d;
    assign out_bool_symbol   = r_out_bool_symbol;
    assign out_comp          = r_out_comp;
    assign out_last          = r_out_last;
    assign busy              = w_busy;
    assign sym_count         = r_sym_count;

endmodule : stage_2_scheduler
`default_nettype wire

// File: tb/tb_stage_2_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_2_scheduler
// Description : Scoreboard bench for stage_2_scheduler. A frame-level model
//               decides grants and expected beats; a monitor compares beats
//               as they leave the output slot. The datapath is a stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_2_scheduler;

    localparam int RW = 16;
    localparam int DS = 5;
    localparam int SW = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic [RW:0]   u;
        logic [RW:0]   v;
        logic [RW-1:0] r;
        logic [DS-1:0] d;
        logic [1:0]    bs;
        logic          comp;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic frame_start = 1'b0, frame_end = 1'b0;
    logic cdf_valid = 1'b0, bool_valid = 1'b0, bool_bit = 1'b0, cdf_comp = 1'b0;
    logic cdf_ready, bool_ready;
    logic [RW-1:0] cdf_uu = '0, cdf_vv = '0, cdf_lut_u = '0, cdf_lut_v = '0;
    logic [RW-1:0] s2_uu, s2_vv, s2_lut_u, s2_lut_v, s2_in_range;
    logic s2_comp, s2_bool_flag;
    logic [SW-1:0] s2_symbol;
    logic [RW:0] s2_u, s2_v_bool;
    logic [RW-1:0] s2_out_range;
    logic [DS-1:0] s2_out_d;
    logic out_valid, out_ready = 1'b0;
    logic [RW:0] out_u, out_v_bool;
    logic [RW-1:0] out_initial_range;
    logic [DS-1:0] out_d;
    logic [1:0] out_bool_symbol;
    logic out_comp, out_last, busy;
    logic [CW-1:0] sym_count;

    logic fixed_range = 1'b0;

    int n_checks = 0;
    int n_errs   = 0;

    // Model state: frame active, flush pending, range, count, last served, slot occupancy
    logic          m_active = 1'b0;
    logic          m_flush  = 1'b0;
    logic [RW-1:0] m_range  = 16'h8000;
    logic [CW-1:0] m_cnt    = '0;
    logic          m_last_bool = 1'b1;
    logic          m_full   = 1'b0;
    beat_t         q[$];

    always #5 clk = ~clk;

    // Datapath stub functions
    function automatic logic [RW-1:0] stub_range(input logic [RW-1:0] rin, input logic [RW-1:0] uu,
                                                 input logic flag, input logic b);
        if (fixed_range) return 16'h9000;
        return (rin ^ uu) + {14'd0, flag, b} + 16'h0135;
    endfunction
    function automatic logic [RW:0] stub_u(input logic [RW-1:0] uu, input logic [RW-1:0] lu);
        return {1'b0, uu} + {1'b0, lu};
    endfunction
    function automatic logic [RW:0] stub_v(input logic [RW-1:0] vv, input logic [RW-1:0] lv, input logic flag);
        return {1'b0, vv} + {1'b0, lv} + {16'd0, flag};
    endfunction
    function automatic logic [DS-1:0] stub_d(input logic [RW-1:0] rin, input logic [RW-1:0] lu);
        return rin[DS-1:0] ^ lu[DS-1:0];
    endfunction

    assign s2_out_range = stub_range(s2_in_range, s2_uu, s2_bool_flag, s2_symbol[0]);
    assign s2_u         = stub_u(s2_uu, s2_lut_u);
    assign s2_v_bool    = stub_v(s2_vv, s2_lut_v, s2_bool_flag);
    assign s2_out_d     = stub_d(s2_in_range, s2_lut_u);

    stage_2_scheduler #(.RANGE_WIDTH(RW), .D_SIZE(DS), .SYMBOL_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .frame_end(frame_end),
        .cdf_valid(cdf_valid), .cdf_ready(cdf_ready), .cdf_uu(cdf_uu), .cdf_vv(cdf_vv),
        .cdf_lut_u(cdf_lut_u), .cdf_lut_v(cdf_lut_v), .cdf_comp(cdf_comp),
        .bool_valid(bool_valid), .bool_ready(bool_ready), .bool_bit(bool_bit),
        .s2_uu(s2_uu), .s2_vv(s2_vv), .s2_lut_u(s2_lut_u), .s2_lut_v(s2_lut_v),
        .s2_in_range(s2_in_range), .s2_comp(s2_comp), .s2_bool_flag(s2_bool_flag),
        .s2_symbol(s2_symbol), .s2_u(s2_u), .s2_v_bool(s2_v_bool),
        .s2_out_range(s2_out_range), .s2_out_d(s2_out_d),
        .out_valid(out_valid), .out_ready(out_ready), .out_u(out_u), .out_v_bool(out_v_bool),
        .out_initial_range(out_initial_range), .out_d(out_d), .out_bool_symbol(out_bool_symbol),
        .out_comp(out_comp), .out_last(out_last), .busy(busy), .sym_count(sym_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted beat must match the oldest expected beat
    always @(negedge clk) begin
        beat_t act, exp;
        #1;
        if (reset_n && out_valid && out_ready) begin
            act = '{u: out_u, v: out_v_bool, r: out_initial_range, d: out_d,
                    bs: out_bool_symbol, comp: out_comp, last: out_last};
            if (q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL beat_unexpected: got %h expected none at %0t", act, $time);
            end else begin
                exp = q.pop_front();
                chk("beat", 64'(act), 64'(exp));
            end
        end
    end

    // One clock of stimulus; bbm selects bool_bit (0/1) or random (2)
    task automatic cycle(input logic fs, input logic fe, input logic cv, input logic bv,
                         input logic ordy, input logic [1:0] bbm);
        logic free, run, idle, g_c, g_b, loaded;
        beat_t b;
        @(negedge clk);
        frame_start = fs; frame_end = fe; cdf_valid = cv; bool_valid = bv; out_ready = ordy;
        cdf_uu = RW'($urandom); cdf_vv = RW'($urandom);
        cdf_lut_u = RW'($urandom); cdf_lut_v = RW'($urandom);
        cdf_comp = 1'($urandom);
        bool_bit = (bbm == 2'd2) ? 1'($urandom) : bbm[0];
        #2;
        free = !m_full || ordy;
        run  = m_active && !m_flush;
        idle = !m_active;
        g_c = 1'b0;
        g_b = 1'b0;
        if (run && !fe && free) begin
            if (cv && bv) begin
                g_c = m_last_bool;
                g_b = !m_last_bool;
            end else begin
                g_c = cv;
                g_b = bv;
            end
        end
        chk("cdf_ready",   64'(cdf_ready),   64'(g_c));
        chk("bool_ready",  64'(bool_ready),  64'(g_b));
        chk("busy",        64'(busy),        64'(m_active));
        chk("sym_count",   64'(sym_count),   64'(m_cnt));
        chk("s2_in_range", 64'(s2_in_range), 64'(m_range));
        chk("out_valid",   64'(out_valid),   64'(m_full));
        loaded = 1'b0;
        if (g_c) begin
            b = '{u: stub_u(cdf_uu, cdf_lut_u), v: stub_v(cdf_vv, cdf_lut_v, 1'b0), r: m_range,
                  d: stub_d(m_range, cdf_lut_u), bs: 2'b00, comp: cdf_comp, last: 1'b0};
            q.push_back(b);
            m_range = stub_range(m_range, cdf_uu, 1'b0, 1'b0);
            m_last_bool = 1'b0;
        end else if (g_b) begin
            b = '{u: stub_u('0, '0), v: stub_v('0, '0, 1'b1), r: m_range,
                  d: stub_d(m_range, '0), bs: {1'b1, bool_bit}, comp: 1'b0, last: 1'b0};
            q.push_back(b);
            m_range = stub_range(m_range, '0, 1'b1, bool_bit);
            m_last_bool = 1'b1;
        end else if (m_flush && free) begin
            b = '0;
            b.r = m_range;
            b.last = 1'b1;
            q.push_back(b);
            loaded = 1'b1;
            m_flush = 1'b0;
            m_active = 1'b0;
        end
        if (g_c || g_b) begin
            loaded = 1'b1;
            if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        if (idle && fs) begin
            m_active = 1'b1;
            m_range = 16'h8000;
            m_cnt = '0;
        end else if (run && fe) begin
            m_flush = 1'b1;
        end
        m_full = loaded || (m_full && !ordy);
    endtask

    // Asynchronous reset pulse with immediate checks of the cleared state
    task automatic do_reset();
        @(negedge clk);
        frame_start = 1'b0; frame_end = 1'b0; cdf_valid = 1'b1; bool_valid = 1'b1; out_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_cdf_rdy",   64'(cdf_ready), 64'd0);
        chk("rst_bool_rdy",  64'(bool_ready), 64'd0);
        chk("rst_count",     64'(sym_count), 64'd0);
        chk("rst_range",     64'(s2_in_range), 64'h8000);
        chk("rst_out_data",  64'({out_u, out_v_bool, out_initial_range, out_d,
                                  out_bool_symbol, out_comp, out_last}), 64'd0);
        m_active = 1'b0; m_flush = 1'b0; m_range = 16'h8000; m_cnt = '0;
        m_last_bool = 1'b1; m_full = 1'b0;
        q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single bool issue against a fixed normalized range
        fixed_range = 1'b1;
        cycle(1, 0, 0, 0, 1, 2'd0);
        cycle(0, 0, 0, 1, 1, 2'd1);
        cycle(0, 0, 0, 0, 1, 2'd0);
        chk("range_after_bool", 64'(s2_in_range), 64'h9000);
        fixed_range = 1'b0;

        // Both requesters contending
        repeat (4) cycle(0, 0, 1, 1, 1, 2'd2);
        cycle(0, 0, 0, 0, 1, 2'd2);

        // Downstream stall then release
        repeat (3) cycle(0, 0, 1, 1, 0, 2'd2);
        repeat (3) cycle(0, 0, 1, 1, 1, 2'd2);

        // Frame end while the slot is stalled
        cycle(0, 0, 1, 0, 0, 2'd2);
        cycle(0, 1, 1, 1, 0, 2'd2);
        cycle(0, 0, 1, 1, 0, 2'd2);
        cycle(0, 0, 1, 1, 1, 2'd2);
        repeat (2) cycle(0, 0, 1, 1, 1, 2'd2);

        // Reset in the middle of a frame with a beat pending
        cycle(1, 0, 0, 0, 1, 2'd2);
        cycle(0, 0, 1, 1, 0, 2'd2);
        do_reset();
        repeat (3) cycle(0, 0, 1, 1, 1, 2'd2);

        // Frame start during RUN is ignored
        cycle(1, 0, 0, 0, 1, 2'd2);
        repeat (2) cycle(0, 0, 1, 1, 1, 2'd2);
        cycle(1, 0, 1, 1, 1, 2'd2);
        repeat (2) cycle(0, 0, 1, 1, 1, 2'd2);

        // Randomized frames
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 29) == 0),
                      1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
                      1'($urandom_range(0, 3) != 0), 2'd2);
            end
        end

        // Drain: close any frame and let the slot empty
        cycle(0, 1, 0, 0, 1, 2'd2);
        repeat (4) cycle(0, 0, 0, 0, 1, 2'd2);
        @(negedge clk);
        #3;
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule : tb_stage_2_scheduler
`default_nettype wire
